// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg
// Shared definitions for the FIFO read-side stream controller.
//   SKID_DEPTH : number of words the output buffer can hold
//   occ_t      : buffer occupancy (0..SKID_DEPTH)
//   has_room   : true when a committed word count still leaves a free slot
package fifo_stream_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // committed = words already buffered + word arriving this cycle - word leaving
  // this cycle. A new read may only be issued if that count leaves one slot free
  // for the word the read will produce two edges from now.
  function automatic logic has_room(input logic [2:0] committed);
    return committed < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// fifo_stream_skid
// Two-entry output buffer between the FIFO read data and the stream port.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   push         : write push_data at the tail this cycle
//   push_data    : word to store
//   pop          : head word leaves this cycle (caller guarantees valid)
//   occ          : current number of stored words
//   valid        : buffer holds at least one word
//   data         : word at the head (zero after reset)
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             head;
  logic             tail;
  occ_t             occ_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      occ_q <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // The head entry is never the one being written while it is visible
  // (occ=1 means tail != head), so data stays stable under back-pressure.
  assign occ   = occ_q;
  assign valid = (occ_q != '0);
  assign data  = mem[head];

  // The issue logic upstream must never let a word arrive into a full buffer.
  overflow_never : assert property (@(posedge clk) disable iff (reset)
    !(push && (occ_q == 2'(SKID_DEPTH)) && !pop));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a synchronous FIFO read port (registered d_out) and presents the
// words as a valid/ready stream, sustaining one word per cycle.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : allows new FIFO reads to be issued
//   fifo_empty   : FIFO empty flag
//   fifo_d_out   : FIFO read data, valid the cycle after fifo_r_enb
//   fifo_r_enb   : FIFO read enable (combinational)
//   m_valid      : stream word available
//   m_ready      : stream consumer accepts
//   m_data       : stream word (buffer head)
//   rd_count     : words delivered, wraps modulo 2^COUNT_W
//   idle         : buffer empty and no read in flight
//
// Handshake: a word transfers on a rising edge where m_valid & m_ready are
// both high. Once m_valid is raised, m_valid and m_data hold until that
// transfer; m_valid never depends combinationally on m_ready.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_d_out,
  output logic               fifo_r_enb,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic [COUNT_W-1:0] rd_count,
  output logic               idle
);

  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] committed;

  assign pop = m_valid & m_ready;

  // A pop implies occ >= 1, so this never goes negative.
  assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_r_enb = enable & ~fifo_empty & has_room(committed);

  // inflight marks that fifo_d_out carries a freshly read word this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= fifo_r_enb;
      if (pop) begin
        rd_count <= rd_count + COUNT_W'(1);
      end
    end
  end

  fifo_stream_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (fifo_d_out),
    .pop       (pop),
    .occ       (occ),
    .valid     (m_valid),
    .data      (m_data)
  );

  assign idle = (occ == 2'd0) & ~inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int W  = 32;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          enable, fifo_empty, fifo_r_enb, m_valid, m_ready, idle;
  logic [W-1:0]  fifo_d_out, m_data;
  logic [CW-1:0] rd_count;

  fifo_stream_reader #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_d_out (fifo_d_out),
    .fifo_r_enb (fifo_r_enb),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_count   (rd_count),
    .idle       (idle)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pops   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural FIFO + scoreboard source ----------------
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q.delete();
      exp_q.delete();
      fifo_d_out <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_r_enb) begin
        if (fifo_q.size() == 0) begin
          n_fail++;
          $display("FAIL read_of_empty_fifo: r_enb=1 with empty FIFO (cycle %0d)", cyc);
        end else begin
          fifo_d_out <= fifo_q.pop_front();
        end
      end
      if (wr_en) begin
        fifo_q.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // ---------------- stream monitor / scoreboard ----------------
  logic         hold = 1'b0;
  logic [W-1:0] hold_data;

  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(hold_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stream_extra_word: got %0h expected no word", m_data);
        end else begin
          check("stream_order", 64'(m_data), 64'(exp_q.pop_front()));
        end
        pops++;
      end
      hold      = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle_drive(input logic en, input logic rdy, input logic we, input logic [W-1:0] wd);
    @(negedge clk);
    enable  = en;
    m_ready = rdy;
    wr_en   = we;
    wr_data = wd;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) cycle_drive(1'b0, 1'b0, 1'b1, base + W'(i));
    cycle_drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic          en;
    logic          rdy;
    logic          exp_enb;
    logic          exp_valid;
    logic [W-1:0]  exp_data;
    logic          exp_idle;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  int           p0, nenb, nv, fe, fv, lv, written;
  logic [W-1:0] got[3];
  logic         we;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;

    // FIFO preloaded with 0x10..0x13, walk through fill, back-pressure,
    // drain and FIFO running empty.
    vecs[0] = '{1, 0, 1, 0, 'h0,  1, 0};
    vecs[1] = '{1, 0, 1, 0, 'h0,  0, 0};
    vecs[2] = '{1, 0, 0, 1, 'h10, 0, 0};
    vecs[3] = '{1, 0, 0, 1, 'h10, 0, 0};
    vecs[4] = '{1, 1, 1, 1, 'h10, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 'h11, 0, 1};
    vecs[6] = '{1, 1, 0, 1, 'h12, 0, 2};
    vecs[7] = '{1, 0, 0, 1, 'h13, 0, 3};
    vecs[8] = '{0, 1, 0, 1, 'h13, 0, 3};
    vecs[9] = '{1, 1, 0, 0, 'h0,  1, 4};

    // reset values
    repeat (2) @(negedge clk);
    #2;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_r_enb", 64'(fifo_r_enb), 64'd0);
    check("rst_count", 64'(rd_count), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // table-driven walk
    preload(4, 'h10);
    for (int i = 0; i < 10; i++) begin
      cycle_drive(vecs[i].en, vecs[i].rdy, 1'b0, '0);
      check($sformatf("tbl%0d_r_enb", i), 64'(fifo_r_enb), 64'(vecs[i].exp_enb));
      check($sformatf("tbl%0d_valid", i), 64'(m_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("tbl%0d_data", i), 64'(m_data), 64'(vecs[i].exp_data));
      check($sformatf("tbl%0d_idle", i), 64'(idle), 64'(vecs[i].exp_idle));
      check($sformatf("tbl%0d_count", i), 64'(rd_count), 64'(vecs[i].exp_cnt));
    end

    // reset mid-stream with a full buffer, then restart
    do_reset();
    preload(3, 'h50);
    for (int i = 0; i < 4; i++) cycle_drive(1'b1, 1'b0, 1'b0, '0);
    check("full_before_reset", 64'(m_valid), 64'd1);
    @(negedge clk);
    #3;
    reset   = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    #1;
    check("midrst_valid", 64'(m_valid), 64'd0);
    check("midrst_idle", 64'(idle), 64'd1);
    check("midrst_count", 64'(rd_count), 64'd0);
    check("midrst_data", 64'(m_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    preload(3, 'hA0);
    fe = -1; fv = -1; lv = -1; nv = 0;
    for (int i = 0; i < 10; i++) begin
      cycle_drive(1'b1, 1'b1, 1'b0, '0);
      if (fifo_r_enb && fe < 0) fe = cyc;
      if (m_valid) begin
        if (fv < 0) fv = cyc;
        if (nv < 3) got[nv] = m_data;
        nv++;
        lv = cyc;
      end
    end
    check("restart_latency", 64'(fv - fe), 64'd2);
    check("restart_words", 64'(nv), 64'd3);
    check("restart_back_to_back", 64'(lv - fv), 64'd2);
    for (int i = 0; i < 3; i++) check($sformatf("restart_word%0d", i), 64'(got[i]), 64'('hA0 + i));
    check("restart_count", 64'(rd_count), 64'd3);

    // back-pressure: only two reads outstanding
    do_reset();
    preload(8, 'h10);
    nenb = 0;
    for (int i = 0; i < 6; i++) begin
      cycle_drive(1'b1, 1'b0, 1'b0, '0);
      nenb += int'(fifo_r_enb);
    end
    check("bp_reads", 64'(nenb), 64'd2);
    check("bp_r_enb_off", 64'(fifo_r_enb), 64'd0);
    check("bp_valid", 64'(m_valid), 64'd1);
    check("bp_head", 64'(m_data), 64'h10);
    p0 = pops; nv = 0;
    for (int i = 0; i < 8; i++) begin
      cycle_drive(1'b1, 1'b1, 1'b0, '0);
      nv += int'(m_valid);
    end
    check("bp_no_gaps", 64'(nv), 64'd8);
    check("bp_delivered", 64'(pops - p0), 64'd8);
    cycle_drive(1'b1, 1'b1, 1'b0, '0);
    check("bp_idle", 64'(idle), 64'd1);

    // enable dropped right after a read was issued
    do_reset();
    preload(3, 'h30);
    cycle_drive(1'b1, 1'b1, 1'b0, '0);
    check("en_fire", 64'(fifo_r_enb), 64'd1);
    p0 = pops; nenb = 0;
    for (int i = 0; i < 6; i++) begin
      cycle_drive(1'b0, 1'b1, 1'b0, '0);
      nenb += int'(fifo_r_enb);
    end
    check("en_off_reads", 64'(nenb), 64'd0);
    check("en_off_inflight_delivered", 64'(pops - p0), 64'd1);
    for (int i = 0; i < 8; i++) cycle_drive(1'b1, 1'b1, 1'b0, '0);
    check("en_on_delivered", 64'(pops - p0), 64'd3);
    check("en_on_idle", 64'(idle), 64'd1);

    // FIFO runs empty after a single word
    do_reset();
    p0 = pops; nenb = 0;
    cycle_drive(1'b1, 1'b1, 1'b1, 'h77);
    for (int i = 0; i < 8; i++) begin
      cycle_drive(1'b1, 1'b1, 1'b0, '0);
      nenb += int'(fifo_r_enb);
      if (fifo_empty) check("r_enb_while_empty", 64'(fifo_r_enb), 64'd0);
    end
    check("empty_reads", 64'(nenb), 64'd1);
    check("empty_delivered", 64'(pops - p0), 64'd1);
    check("empty_idle", 64'(idle), 64'd1);

    // counter wrap with 17 words at COUNT_W=4
    do_reset();
    preload(17, 'h100);
    p0 = pops;
    for (int i = 0; i < 25; i++) cycle_drive(1'b1, 1'b1, 1'b0, '0);
    check("wrap_delivered", 64'(pops - p0), 64'd17);
    check("wrap_count", 64'(rd_count), 64'd1);

    // random traffic: concurrent writes, random enable and ready
    do_reset();
    p0 = pops; written = 0;
    for (int i = 0; i < 20000 && (pops - p0) < 1000; i++) begin
      we = (written < 1000) && ($urandom_range(0, 9) < 6);
      cycle_drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), we, $urandom);
      written += int'(we);
    end
    cycle_drive(1'b0, 1'b0, 1'b0, '0);
    check("rand_delivered", 64'(pops - p0), 64'd1000);
    check("rand_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("rand_count", 64'(rd_count), 64'(1000 % 16));
    for (int i = 0; i < 4; i++) cycle_drive(1'b1, 1'b1, 1'b0, '0);
    check("rand_no_extra", 64'(pops - p0), 64'd1000);
    check("rand_idle", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side controller that drains the team's synchronous FIFO read port (r_enb/d_out/empty) and presents the words as a valid/ready stream. The FIFO's d_out is registered, so data is valid one cycle after an accepted read. A 2-entry output buffer absorbs that latency and downstream back-pressure, sustaining one word per cycle. The block sits between any synchronous FIFO instance and a stream consumer, and counts delivered words.

Parameters:
WIDTH, 32, data width; must equal the attached FIFO's WIDTH
COUNT_W, 16, width of delivered-word counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  permits issuing new FIFO reads
fifo_empty  input  1  FIFO empty flag
fifo_d_out  input  WIDTH  FIFO registered read data
fifo_r_enb  output  1  FIFO read enable (combinational)
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  WIDTH  stream data (buffer head)
rd_count  output  COUNT_W  words delivered downstream, wraps modulo 2^COUNT_W
idle  output  1  buffer empty and no read in flight

Behaviour:
- Reset (async, active-high) clears to zero: buffer occupancy, head/tail pointers, inflight flag, rd_count and m_data. Reset values: m_valid=0, idle=1, fifo_r_enb=0 (all contributing state is cleared).
- pop = m_valid & m_ready. A stream transfer occurs on the rising edge where pop=1.
- inflight register: set to fifo_r_enb each cycle, marking that fifo_d_out carries a new word this cycle.
- fifo_r_enb = enable & !fifo_empty & ((occ + inflight - pop) < 2). It never issues when no slot is guaranteed. This is a combinational path from m_ready and fifo_empty.
- Capture: when inflight=1, fifo_d_out is written at the tail; the tail pointer (1 bit) toggles.
- Pop advances the head pointer (1 bit).
- occ is 0..2 and is updated by +capture -pop. Simultaneous capture and pop leaves occ unchanged. Overflow (capture with occ=2 and no pop) is impossible by construction; assert it in simulation.
- m_valid = (occ != 0). m_data = buffer[head]. m_data must remain stable while m_valid & !m_ready.
- Latency: the first word appears on m_valid the cycle after the capture. That is, fifo_r_enb in cycle N gives inflight and capture at the edge ending N+1, and m_valid=1 in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, one word per cycle after the initial 2-cycle latency.
- Ordering is strictly FIFO. No word may be dropped or duplicated.
- enable low: no new reads. An inflight word is still captured and buffered words still drain.
- fifo_empty asserting mid-stream: reads stop. Buffered and inflight words still drain.
- rd_count increments on each pop and wraps from 2^COUNT_W-1 to 0.
- idle = (occ==0) & !inflight.
- Reset mid-operation: buffered and inflight words are discarded. The FIFO pointer advance already performed is not undone; the FIFO should be reset together with this block.
- The FIFO's own reset is active-low; the integrating level inverts reset for it.

Decomposition:
- Package fifo_stream_pkg: localparam SKID_DEPTH=2; occupancy type (2 bits).
- Sub-module fifo_stream_skid: 2-entry buffer with push/pop, head/tail pointers, occ, valid/data out.
- The top level holds the issue logic, the inflight flag, rd_count and idle.

Test Plan:
- Reset mid-stream: assert reset with occ=2 -> m_valid=0, idle=1, rd_count=0 and m_data=0 immediately (async). Then preload the FIFO with 0xA0,0xA1,0xA2 and set m_ready=1, enable=1 -> m_data sequence 0xA0,0xA1,0xA2 on consecutive cycles; first m_valid 2 cycles after the first fifo_r_enb; rd_count=3.
- Back-pressure: FIFO holds 0x10..0x17 and m_ready=0 -> exactly 2 reads issued, occ=2, fifo_r_enb=0 thereafter, m_data held at 0x10. Release m_ready -> 0x10..0x17 in order, no gaps after restart.
- Random m_ready (50%) with 1000 words, with concurrent FIFO writes and reads -> scoreboard exact order match, no loss or duplication, overflow assertion never fires.
- enable deasserted the same cycle fifo_r_enb fired -> the inflight word is still delivered; no further fifo_r_enb until enable=1.
- FIFO runs empty: 1 word written, then empty -> 1 word delivered, idle returns to 1, and fifo_r_enb stays 0 while fifo_empty=1.
- COUNT_W=4 with 17 words -> rd_count wraps to 1.
